// File: rtl/vc_arbiter.sv
// -----------------------------------------------------------------------------
// vc_arbiter
//
// Round-robin arbiter that shares one router output channel among NUM_VC
// virtual-channel requesters. A registered one-hot grant is issued and held
// for the whole packet until the owner signals the end of the packet. A
// starvation guard forcibly withdraws a grant that has been held for
// MAX_HOLD cycles (MAX_HOLD = 0 disables the guard).
//
// Parameters
//   NUM_VC      number of requesting virtual channels (power of two, >= 2)
//   ID_W        width of grant_id, equal to log2(NUM_VC)
//   MAX_HOLD    maximum number of cycles a grant may be held, 0 = unlimited
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous active-low reset
//   en           in   1        advance enable; when low all state is frozen
//   req          in   NUM_VC   per-VC request
//   pkt_release  in   1        owner has sent its tail flit (only used in BUSY)
//   grant        out  NUM_VC   registered one-hot grant, zero when idle
//   grant_valid  out  1        high while any grant is held
//   grant_id     out  ID_W     binary index of the owner, holds when idle
//   preempt      out  1        one-cycle pulse when the guard withdraws a grant
//
// The tail-flit input is named pkt_release because "release" is a reserved
// word in SystemVerilog (force/release) and cannot be used as a port name.
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module vc_arbiter #(
   parameter int NUM_VC   = 4,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [NUM_VC-1:0] req,
   input  logic              pkt_release,
   output logic [NUM_VC-1:0] grant,
   output logic              grant_valid,
   output logic [ID_W-1:0]   grant_id,
   output logic              preempt
);

   // Hold counter must be able to represent MAX_HOLD itself; keep at least
   // one bit so the design still elaborates with the guard disabled.
   localparam int HCNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

   localparam logic [HCNT_W-1:0] HCNT_ZERO = {HCNT_W{1'b0}};
   localparam logic [HCNT_W-1:0] HCNT_ONE  = {{(HCNT_W-1){1'b0}}, 1'b1};
   localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(MAX_HOLD);
   localparam logic [ID_W-1:0]   ID_ZERO   = {ID_W{1'b0}};
   localparam logic [ID_W-1:0]   ID_ONE    = {{(ID_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_VC-1:0] GNT_ZERO  = {NUM_VC{1'b0}};
   localparam logic [NUM_VC-1:0] GNT_ONE   = {{(NUM_VC-1){1'b0}}, 1'b1};
   localparam logic              GUARD_ON  = (MAX_HOLD != 0) ? 1'b1 : 1'b0;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_r;
   logic [ID_W-1:0]     ptr_r;
   logic [HCNT_W-1:0]   hcnt_r;
   logic [NUM_VC-1:0]   grant_r;
   logic                grant_valid_r;
   logic [ID_W-1:0]     grant_id_r;
   logic                preempt_r;

   logic                win_found_s;
   logic                win_hit_s;
   logic [ID_W-1:0]     win_id_s;
   logic [ID_W-1:0]     cand_s;
   logic [ID_W-1:0]     next_ptr_s;
   logic                force_s;

   // Round-robin winner: first requesting VC scanning upward from ptr_r.
   // The candidate index is ID_W bits wide, so the addition wraps modulo
   // NUM_VC on its own.
   always_comb begin
      win_found_s = 1'b0;
      win_hit_s   = 1'b0;
      win_id_s    = ptr_r;
      cand_s      = ptr_r;
      for (int k = 0; k < NUM_VC; k++) begin
         cand_s      = ptr_r + ID_W'(k);
         win_hit_s   = (~win_found_s) & req[cand_s];
         win_id_s    = win_hit_s ? cand_s : win_id_s;
         win_found_s = win_found_s | win_hit_s;
      end
   end

   // Pointer after a grant ends: the VC just past the current owner.
   always_comb begin
      next_ptr_s = grant_id_r + ID_ONE;
   end

   // Starvation guard trip condition (release still takes priority).
   always_comb begin
      if (GUARD_ON && (hcnt_r == HCNT_MAX)) begin
         force_s = 1'b1;
      end else begin
         force_s = 1'b0;
      end
   end

   // Arbitration FSM with registered outputs, pointer and hold counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         ptr_r         <= ID_ZERO;
         hcnt_r        <= HCNT_ZERO;
         grant_r       <= GNT_ZERO;
         grant_valid_r <= 1'b0;
         grant_id_r    <= ID_ZERO;
         preempt_r     <= 1'b0;
      end else begin
         // preempt is a single-cycle pulse; only the forcing edge sets it.
         preempt_r <= 1'b0;
         if (en) begin
            case (state_r)
               IDLE: begin
                  if (win_found_s) begin
                     grant_r       <= GNT_ONE << win_id_s;
                     grant_valid_r <= 1'b1;
                     grant_id_r    <= win_id_s;
                     hcnt_r        <= HCNT_ONE;
                     state_r       <= BUSY;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               BUSY: begin
                  // req is deliberately ignored here: only the end of the
                  // packet or the guard can end a grant.
                  if (pkt_release) begin
                     grant_r       <= GNT_ZERO;
                     grant_valid_r <= 1'b0;
                     ptr_r         <= next_ptr_s;
                     hcnt_r        <= HCNT_ZERO;
                     state_r       <= IDLE;
                  end else if (force_s) begin
                     grant_r       <= GNT_ZERO;
                     grant_valid_r <= 1'b0;
                     ptr_r         <= next_ptr_s;
                     hcnt_r        <= HCNT_ZERO;
                     preempt_r     <= 1'b1;
                     state_r       <= IDLE;
                  end else if (hcnt_r < HCNT_MAX) begin
                     hcnt_r <= hcnt_r + HCNT_ONE;
                  end else begin
                     hcnt_r <= hcnt_r;
                  end
               end
               default: begin
                  // Unreachable encoding: fall back to a safe idle state.
                  grant_r       <= GNT_ZERO;
                  grant_valid_r <= 1'b0;
                  hcnt_r        <= HCNT_ZERO;
                  state_r       <= IDLE;
               end
            endcase
         end else begin
            // Frozen: a release presented now is intentionally dropped.
            state_r <= state_r;
         end
      end
   end

   assign grant       = grant_r;
   assign grant_valid = grant_valid_r;
   assign grant_id    = grant_id_r;
   assign preempt     = preempt_r;

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Round-robin arbiter that shares one router output channel among `NUM_VC` virtual-channel requesters. It issues a registered one-hot grant and holds it for the whole packet until the owner signals `release`. It includes a starvation guard that forcibly pre-empts an owner after `MAX_HOLD` cycles. It sits between the per-VC input buffers and the output crossbar select, and drives the crossbar select and the per-VC ownership flags.

## Interface

**Parameters**
- `NUM_VC`, 4: number of requesting virtual channels. Must be a power of two and ≥ 2.
- `ID_W`, 2: width of `grant_id`. Must equal log2(`NUM_VC`).
- `MAX_HOLD`, 16: maximum number of cycles a grant may be held. 0 disables the guard.

**Ports**
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. Asserts immediately; deassertion is taken synchronously by the surrounding design.
- `en`  in  1: advance enable. When low, all state (FSM, pointer, grant, counter) is frozen.
- `req`  in  `NUM_VC`: per-VC request; bit i high means VC i has a packet for this output.
- `release`  in  1: current owner has sent its tail flit. Meaningful only in BUSY.
- `grant`  out  `NUM_VC`: registered one-hot grant; all zeros when idle.
- `grant_valid`  out  1: high while any grant is held (OR of `grant`).
- `grant_id`  out  `ID_W`: binary index of the owner. Holds its last value when idle.
- `preempt`  out  1: one-cycle pulse when a grant is forcibly withdrawn by the starvation guard.

## Operation

**State**
- FSM with two states, IDLE and BUSY.
- Round-robin pointer `ptr` (`ID_W` bits).
- Hold counter `hcnt`, wide enough to count to `MAX_HOLD`.

**Reset values**
- FSM = IDLE, `ptr` = 0, `hcnt` = 0.
- `grant` = 0, `grant_valid` = 0, `grant_id` = 0, `preempt` = 0.

**IDLE, with `en` = 1 and `req` ≠ 0**
- Winner = first set bit of `req` scanning upward from `ptr`, wrapping from `NUM_VC`-1 to 0.
- On the edge: `grant` = one-hot(winner), `grant_id` = winner, `hcnt` = 1, go to BUSY.

**IDLE, with `req` = 0 or `en` = 0**
- Remain in IDLE; all outputs unchanged.
- `release` is ignored.

**BUSY, with `en` = 1**
- `grant` is held regardless of changes on `req`, including the owner dropping its request. Only `release` or pre-emption ends a grant.
- If `release` = 1: clear `grant`, set `ptr` = (`grant_id` + 1) mod `NUM_VC`, `hcnt` = 0, go to IDLE. `release` has priority over pre-emption in the same cycle; `preempt` stays 0.
- Else if `MAX_HOLD` ≠ 0 and `hcnt` == `MAX_HOLD`: treat as a release (same updates), and additionally pulse `preempt` = 1 for one cycle.
- Else: `hcnt` = `hcnt` + 1, saturating at `MAX_HOLD`.

**BUSY, with `en` = 0**
- Everything frozen, including `hcnt`. A `release` seen while `en` = 0 is lost; the owner must hold `release` until it is accepted.

**Arithmetic**
- Pointer wrap is modulo `NUM_VC`, with no sign extension.
- `grant_id` is always consistent with `grant` whenever `grant_valid` = 1.

## Timing

- Grant latency: `req` sampled at edge n, so `grant` is visible after edge n (one cycle, registered).
- Release-to-idle: `release` sampled at edge n, so `grant` = 0 after edge n.
- A new grant can appear no earlier than edge n+1. There is always at least one idle cycle between owners.
- `preempt` is high for exactly the cycle following the forcing edge and coincides with `grant` = 0.
- Reset mid-packet clears `grant` asynchronously, within the same cycle, with no `preempt` pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

1. **Reset:** hold `reset` = 0 with `req` = 4'b1111. All outputs must be 0; after release from reset, the first grant goes to VC0 (`grant` = 4'b0001, `grant_id` = 0).
2. **Round robin:** keep `req` = 4'b1111 and pulse `release` 1 cycle after each grant. Grant order must be VC0, VC1, VC2, VC3, VC0, with exactly one idle cycle between grants.
3. **Sparse wrap:** from `ptr` = 3, set `req` = 4'b0101. Must grant VC0; after its release, must grant VC2.
4. **Hold and freeze:** grant VC1, drop `req[1]`, then set `en` = 0 for 5 cycles while pulsing `release`. `grant` must stay 4'b0010 throughout and `hcnt` must not advance.
5. **Pre-emption:** with `MAX_HOLD` = 16, grant VC2 and never assert `release`. `grant` must clear exactly 16 cycles after it appeared, with a one-cycle `preempt` pulse, and the next grant must go to VC3 if it is requesting.
6. **Simultaneous events:** assert `release` in the same cycle `hcnt` reaches `MAX_HOLD`, and separately reset asynchronously mid-grant. The first case gives a normal release with `preempt` = 0; the second clears `grant` before the next clock edge.
